// File: rtl/shift_reg_credit_sink_if.sv
// Bundle between delay-line producer, credit sink and downstream consumer.
// The slave side is the sink; the master side is the surrounding datapath.
interface shift_reg_credit_sink_if #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8
);
  localparam int CW = $clog2(DEPTH + 1);

  logic             send;
  logic             credit;
  logic             in_valid;
  logic [WIDTH-1:0] in;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out;
  logic [CW-1:0]    count;
  logic             err;

  modport master (
    output send, in_valid, in, out_ready,
    input  credit, out_valid, out, count, err
  );

  modport slave (
    input  send, in_valid, in, out_ready,
    output credit, out_valid, out, count, err
  );
endinterface

// File: rtl/shift_reg_credit_sink.sv
// Credit-gated catch FIFO at the tail of a fixed-latency delay line.
// Credits cover FIFO words plus words still travelling down the line.
module shift_reg_credit_sink #(
  parameter int WIDTH = 32,
  parameter int DELAY = 2,
  parameter int DEPTH = 8
) (
  input logic                    CLK,
  input logic                    RST_N,
  shift_reg_credit_sink_if.slave bus
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  localparam logic [CW:0]   CAP  = (CW + 1)'(DEPTH);

  if (DELAY < 1 || DEPTH < 2) begin : g_bad_param
    $error("shift_reg_credit_sink: need DELAY>=1 and DEPTH>=2");
  end

  logic [CW-1:0]    occ, occ_n;
  logic [CW-1:0]    inflight, inflight_n;
  logic [PW-1:0]    wr_ptr, wr_ptr_n;
  logic [PW-1:0]    rd_ptr, rd_ptr_n;
  logic             err_q, err_n;
  logic [WIDTH-1:0] mem [DEPTH];

  logic [CW:0] used;
  logic        launch, arrive, rd, wr, drop;
  logic        bad_send, bad_arrive;

  assign used   = {1'b0, occ} + {1'b0, inflight};
  assign launch = bus.send & bus.credit;
  assign arrive = bus.in_valid & (inflight != '0);
  assign rd     = bus.out_valid & bus.out_ready;
  // Unreachable with correct credits; kept so a broken producer
  // cannot overwrite the head.
  assign drop   = arrive & (occ == FULL) & !rd;
  assign wr     = arrive & !drop;

  assign bad_send   = bus.send & !bus.credit;
  assign bad_arrive = bus.in_valid & (inflight == '0);

  assign bus.credit    = used < CAP;
  assign bus.out_valid = occ != '0;
  assign bus.out       = mem[rd_ptr];
  assign bus.count     = occ;
  assign bus.err       = err_q;

  always_comb begin
    inflight_n = inflight;
    occ_n      = occ;
    wr_ptr_n   = wr_ptr;
    rd_ptr_n   = rd_ptr;
    err_n      = err_q;

    unique case ({launch, arrive})
      2'b10:   inflight_n = inflight + CW'(1);
      2'b01:   inflight_n = inflight - CW'(1);
      default: inflight_n = inflight;
    endcase

    unique case ({wr, rd})
      2'b10:   occ_n = occ + CW'(1);
      2'b01:   occ_n = occ - CW'(1);
      default: occ_n = occ;
    endcase

    if (wr) begin
      wr_ptr_n = (wr_ptr == LAST) ? '0 : wr_ptr + PW'(1);
    end
    if (rd) begin
      rd_ptr_n = (rd_ptr == LAST) ? '0 : rd_ptr + PW'(1);
    end

    unique case (1'b1)
      bad_send:   err_n = 1'b1;
      bad_arrive: err_n = 1'b1;
      drop:       err_n = 1'b1;
      default:    err_n = err_q;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      occ      <= '0;
      inflight <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      err_q    <= 1'b0;
    end else begin
      occ      <= occ_n;
      inflight <= inflight_n;
      wr_ptr   <= wr_ptr_n;
      rd_ptr   <= rd_ptr_n;
      err_q    <= err_n;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST_N && wr) begin
      mem[wr_ptr] <= bus.in;
    end
  end
endmodule

// File: tb/tb_shift_reg_credit_sink.sv
// Directed bench: two sinks (DEPTH 4 and 5) each fed by a 2-stage
// delay-line model that is cleared by the same reset.
module tb_shift_reg_credit_sink;
  localparam int W  = 32;
  localparam int DL = 2;

  logic CLK = 1'b0;
  logic RST_N = 1'b0;
  always #5 CLK = ~CLK;

  shift_reg_credit_sink_if #(.WIDTH(W), .DEPTH(4)) ba ();
  shift_reg_credit_sink_if #(.WIDTH(W), .DEPTH(5)) bb ();

  shift_reg_credit_sink #(.WIDTH(W), .DELAY(DL), .DEPTH(4)) dut_a (
    .CLK(CLK), .RST_N(RST_N), .bus(ba)
  );
  shift_reg_credit_sink #(.WIDTH(W), .DELAY(DL), .DEPTH(5)) dut_b (
    .CLK(CLK), .RST_N(RST_N), .bus(bb)
  );

  logic         sa, sb, ra, rb, inja;
  logic [W-1:0] da, db, injd;
  logic [DL-1:0] pva, pvb;
  logic [W-1:0] pda [DL];
  logic [W-1:0] pdb [DL];

  assign ba.send      = sa;
  assign ba.out_ready = ra;
  assign ba.in_valid  = inja | pva[DL-1];
  assign ba.in        = inja ? injd : pda[DL-1];
  assign bb.send      = sb;
  assign bb.out_ready = rb;
  assign bb.in_valid  = pvb[DL-1];
  assign bb.in        = pdb[DL-1];

  // Delay lines: a word enters only when the producer's send is granted.
  always @(posedge CLK) begin
    if (!RST_N) begin
      pva <= '0;
      pvb <= '0;
    end else begin
      pva <= {pva[DL-2:0], sa & ba.credit};
      pvb <= {pvb[DL-2:0], sb & bb.credit};
      for (int i = DL - 1; i > 0; i--) begin
        pda[i] <= pda[i-1];
        pdb[i] <= pdb[i-1];
      end
      pda[0] <= da;
      pdb[0] <= db;
    end
  end

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        s;
    logic        r;
    logic [31:0] d;
    logic        e_cr;
    logic        e_ov;
    int          e_cnt;
    logic [31:0] e_out;
  } vec_t;

  vec_t fill [12];
  logic [31:0] q [$];
  logic [31:0] exp_w;
  int exp_n, first, seq, seen;

  initial begin
    #100000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    fill[0]  = '{1'b1, 1'b0, 32'd1, 1'b1, 1'b0, 0, 32'd0};
    fill[1]  = '{1'b1, 1'b0, 32'd2, 1'b1, 1'b0, 0, 32'd0};
    fill[2]  = '{1'b1, 1'b0, 32'd3, 1'b1, 1'b0, 0, 32'd0};
    fill[3]  = '{1'b1, 1'b0, 32'd4, 1'b1, 1'b1, 1, 32'd1};
    fill[4]  = '{1'b0, 1'b0, 32'd0, 1'b0, 1'b1, 2, 32'd1};
    fill[5]  = '{1'b0, 1'b0, 32'd0, 1'b0, 1'b1, 3, 32'd1};
    fill[6]  = '{1'b0, 1'b0, 32'd0, 1'b0, 1'b1, 4, 32'd1};
    fill[7]  = '{1'b0, 1'b1, 32'd0, 1'b0, 1'b1, 4, 32'd1};
    fill[8]  = '{1'b0, 1'b1, 32'd0, 1'b1, 1'b1, 3, 32'd2};
    fill[9]  = '{1'b0, 1'b1, 32'd0, 1'b1, 1'b1, 2, 32'd3};
    fill[10] = '{1'b0, 1'b1, 32'd0, 1'b1, 1'b1, 1, 32'd4};
    fill[11] = '{1'b0, 1'b0, 32'd0, 1'b1, 1'b0, 0, 32'd0};

    sa = 0; sb = 0; ra = 0; rb = 0; inja = 0;
    da = 0; db = 0; injd = 0;

    // Reset held with random traffic on the inputs
    RST_N = 1'b0;
    @(negedge CLK);
    for (int i = 0; i < 3; i++) begin
      chk("rst_credit", 32'(ba.credit), 32'd1);
      chk("rst_ovalid", 32'(ba.out_valid), 32'd0);
      chk("rst_count", 32'(ba.count), 32'd0);
      chk("rst_err", 32'(ba.err), 32'd0);
      sa = 1'($urandom); ra = 1'($urandom); inja = 1'($urandom);
      injd = $urandom; da = $urandom;
      @(negedge CLK);
    end
    sa = 0; ra = 0; inja = 0;
    RST_N = 1'b1;
    @(negedge CLK);
    chk("rst_err_after", 32'(ba.err), 32'd0);
    chk("rst_credit_after", 32'(ba.credit), 32'd1);

    // Fill DEPTH=4 with out_ready low, then drain
    for (int i = 0; i < 12; i++) begin
      chk($sformatf("fill%0d_credit", i), 32'(ba.credit), 32'(fill[i].e_cr));
      chk($sformatf("fill%0d_ovalid", i), 32'(ba.out_valid),
          32'(fill[i].e_ov));
      chk($sformatf("fill%0d_count", i), 32'(ba.count), 32'(fill[i].e_cnt));
      if (fill[i].e_ov)
        chk($sformatf("fill%0d_out", i), ba.out, fill[i].e_out);
      sa = fill[i].s; ra = fill[i].r; da = fill[i].d;
      @(negedge CLK);
    end
    chk("fill_err", 32'(ba.err), 32'd0);

    // Streaming: 100 back-to-back words, out_ready high
    exp_n = 0; first = -1;
    for (int c = 0; c < 110; c++) begin
      if (c < 100) chk($sformatf("stream%0d_credit", c), 32'(ba.credit), 32'd1);
      if (ba.out_valid) begin
        if (first < 0) first = c;
        chk($sformatf("stream_out%0d", exp_n), ba.out, 32'(exp_n));
        exp_n++;
      end
      sa = (c < 100); da = 32'(c); ra = 1'b1;
      @(negedge CLK);
    end
    sa = 0;
    chk("stream_first", 32'(first), 32'd3);
    chk("stream_words", 32'(exp_n), 32'd100);
    chk("stream_err", 32'(ba.err), 32'd0);

    // Backpressure 1,0,0,1 on DEPTH=5 with greedy producer
    seq = 1;
    for (int c = 0; c < 50; c++) begin
      rb = (c % 4 == 0) || (c % 4 == 3);
      chk("bp_count_le5", 32'(bb.count <= 5), 32'd1);
      if (bb.out_valid && rb) begin
        exp_w = (q.size() > 0) ? q.pop_front() : 32'hBAD0BAD0;
        chk("bp_out", bb.out, exp_w);
      end
      sb = bb.credit;
      db = 32'(seq);
      if (sb) begin
        q.push_back(32'(seq));
        seq++;
      end
      @(negedge CLK);
    end
    sb = 0;
    for (int c = 0; c < 20; c++) begin
      rb = 1'b1;
      if (bb.out_valid) begin
        exp_w = (q.size() > 0) ? q.pop_front() : 32'hBAD0BAD0;
        chk("bp_drain_out", bb.out, exp_w);
      end
      @(negedge CLK);
    end
    rb = 0;
    chk("bp_left", 32'(q.size()), 32'd0);
    chk("bp_empty", 32'(bb.out_valid), 32'd0);
    chk("bp_enough", 32'(seq > 20), 32'd1);
    chk("bp_err", 32'(bb.err), 32'd0);

    // Mid-stream reset: 3 buffered + 2 in flight on DEPTH=5
    for (int i = 0; i < 5; i++) begin
      sb = 1'b1; db = 32'(100 + i);
      @(negedge CLK);
    end
    sb = 0;
    chk("mid_count_pre", 32'(bb.count), 32'd3);
    chk("mid_credit_pre", 32'(bb.credit), 32'd0);
    RST_N = 1'b0;
    @(negedge CLK);
    RST_N = 1'b1;
    chk("mid_count", 32'(bb.count), 32'd0);
    chk("mid_ovalid", 32'(bb.out_valid), 32'd0);
    chk("mid_credit", 32'(bb.credit), 32'd1);
    sb = 1'b1; db = 32'hAB;
    @(negedge CLK);
    sb = 0; rb = 1'b1;
    seen = -1;
    for (int c = 1; c < 8; c++) begin
      if (bb.out_valid && seen < 0) begin
        seen = c;
        chk("mid_new_word", bb.out, 32'hAB);
      end
      @(negedge CLK);
    end
    rb = 0;
    chk("mid_latency", 32'(seen), 32'd3);
    chk("mid_count_end", 32'(bb.count), 32'd0);
    chk("mid_err", 32'(bb.err), 32'd0);

    // Violation: send with credit=0 on a full DEPTH=4 FIFO
    ra = 0;
    for (int i = 0; i < 7; i++) begin
      sa = (i < 4); da = 32'(200 + i);
      @(negedge CLK);
    end
    sa = 0;
    chk("vio_full_count", 32'(ba.count), 32'd4);
    chk("vio_full_credit", 32'(ba.credit), 32'd0);
    chk("vio_pre_err", 32'(ba.err), 32'd0);
    sa = 1'b1;
    @(negedge CLK);
    sa = 0;
    chk("vio_send_err", 32'(ba.err), 32'd1);
    chk("vio_send_count", 32'(ba.count), 32'd4);
    ra = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("vio_drain_out", ba.out, 32'(200 + i));
      @(negedge CLK);
    end
    ra = 0;
    chk("vio_drained", 32'(ba.count), 32'd0);
    for (int i = 0; i < 6; i++) begin
      sa = (i < 3); da = 32'(300 + i);
      @(negedge CLK);
    end
    sa = 0;
    chk("vio_inflight_count", 32'(ba.count), 32'd3);
    chk("vio_inflight_credit", 32'(ba.credit), 32'd1);

    // Violation: stray arrival with nothing launched
    RST_N = 1'b0;
    @(negedge CLK);
    RST_N = 1'b1;
    chk("stray_pre_err", 32'(ba.err), 32'd0);
    inja = 1'b1; injd = 32'hDEAD;
    @(negedge CLK);
    inja = 0;
    chk("stray_err", 32'(ba.err), 32'd1);
    chk("stray_count", 32'(ba.count), 32'd0);
    @(negedge CLK);
    chk("stray_ovalid", 32'(ba.out_valid), 32'd0);
    chk("stray_err_sticky", 32'(ba.err), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
